gaussian_tile_binner: RTL and testbench
=======================================

# gaussian_tile_binner

Downstream neighbour of the Gaussian preprocess stage. It consumes one projected Gaussian per handshake: screen-space centre, depth and screen-space extent. It computes the clamped rectangle of screen tiles the Gaussian overlaps, then streams one (tile_id, gaussian_id, depth) entry per covered tile to the sort/rasteriser input, one entry per cycle under backpressure.

## Interface
Parameters:
- DATA_WIDTH, 16, width of coordinate/extent/depth words
- TILE_SHIFT, 4, log2 of tile edge in pixels (16x16 tiles)
- TILES_X, 40, tile columns (640 px)
- TILES_Y, 23, tile rows (368 px)
- ID_WIDTH, 16, Gaussian id width
- TILE_ID_WIDTH, 10, width of tile_id; must satisfy 2^TILE_ID_WIDTH >= TILES_X*TILES_Y

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream Gaussian valid
- in_ready  out  1  block can accept a Gaussian
- p_project_i  in  DATA_WIDTH x3  [0] x pixel (signed integer), [1] y pixel (signed integer), [2] depth (unsigned)
- Ttrans_i  in  DATA_WIDTH x3  [0] x extent rx (unsigned pixels), [1] y extent ry (unsigned pixels), [2] unused
- out_valid  out  1  entry valid
- out_ready  in  1  downstream accepts entry
- tile_id_o  out  TILE_ID_WIDTH  ty*TILES_X+tx
- gauss_id_o  out  ID_WIDTH  index of source Gaussian
- depth_o  out  DATA_WIDTH  depth of source Gaussian
- last_o  out  1  final entry of this Gaussian
- cull_o  out  1  one-cycle pulse: Gaussian produced zero entries

## Operation
- FSM states: IDLE, CALC, EMIT.
- IDLE: in_ready=1. On in_valid, register inputs, then go to CALC.
- CALC: compute the tile rectangle in DATA_WIDTH+2 signed arithmetic, with arithmetic right shift.
  - xmin = clamp((x-rx)>>>TILE_SHIFT, 0, TILES_X)
  - xmax = clamp((x+rx+2^TILE_SHIFT-1)>>>TILE_SHIFT, 0, TILES_X) (exclusive)
  - ymin and ymax: same form using y, ry and TILES_Y.
- Empty case: the Gaussian is empty if xmin>=xmax, ymin>=ymax, or depth==0. Pulse cull_o and return to IDLE with no entries.
- Otherwise: load tx=xmin, ty=ymin, then go to EMIT.
- EMIT: present the entry (tile_id, gauss_id, depth). On out_valid&&out_ready:
  - tx increments.
  - At tx==xmax-1, tx wraps to xmin and ty increments.
  - The entry with tx==xmax-1 and ty==ymax-1 has last_o=1; its handshake returns the FSM to IDLE.
- Order is row-major, tx innermost.
- tile_id is computed as ty*TILES_X+tx, using a constant multiply or a running row-base register.
- gauss_id counter: increments once per accepted Gaussian, including culled ones, and wraps modulo 2^ID_WIDTH.

## Timing
- Reset values: in_ready=0 during reset and 1 the cycle after; out_valid=0, last_o=0, cull_o=0, tile_id_o=0, gauss_id_o=0, depth_o=0. The gauss_id counter resets to 0 and the FSM to IDLE.
- Latency: accept at cycle N; CALC in N+1; first out_valid at N+2. cull_o is asserted in N+2 and in_ready returns in N+2.
- After the last handshake at cycle M, in_ready=1 at M+1. There is no accept during CALC or EMIT.
- Throughput: 1 entry/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, all outputs hold stable. out_valid never drops without a handshake.
- Reset asserted mid-EMIT: the entry is abandoned, with no last_o. Everything returns to reset values on the next edge.
- Extents large enough to overflow DATA_WIDTH are handled by the +2 guard bits; clamping makes them safe.

## Configuration
- TILE_BINNER_STATS_EN defined: adds outputs stat_entries_o (32b, count of entry handshakes) and stat_culled_o (32b, count of cull_o pulses). Both saturate at all-ones and clear on rst_i.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package gs_pkg holds:
  - TILE_SHIFT, TILES_X and TILES_Y defaults
  - typedef tile_rect_t {xmin, xmax, ymin, ymax}
  - typedef tile_entry_t {tile_id, gauss_id, depth}
- One sub-module, tile_rect_calc: purely combinational, computing centre/extent to tile_rect_t plus an empty flag. It is used in CALC and unit-testable alone.

## Test plan
- Defaults, x=40, y=40, rx=ry=8, depth=100, out_ready=1 -> single entry tile_id=82, gauss_id=0, last_o=1, first out_valid 2 cycles after accept.
- x=40, y=40, rx=ry=16 -> 9 entries with tile_id 41,42,43,81,82,83,121,122,123 on consecutive cycles; last_o only on 123.
- x=-100, y=40, r=8 -> cull_o pulse, no out_valid; next Gaussian gets gauss_id=1.
- Edge clamp: x=635, y=360, r=16 -> tile_ids 878,879,918,919.
- Previous case with out_ready toggling 1,0,0,1,... -> outputs held while stalled; same 4 entries in order, none duplicated or lost.
- rst_i pulsed after the 3rd of 9 entries -> next cycle out_valid=0, gauss_id counter=0; the next Gaussian restarts cleanly with gauss_id=0.

Source files
------------

// File: rtl/gs_pkg.sv
// Shared types for the Gaussian splatting tile-binning path.
// Holds tile-grid defaults, tile rectangle and entry bundles.
package gs_pkg;

  localparam int DEF_TILE_SHIFT = 4;
  localparam int DEF_TILES_X    = 40;
  localparam int DEF_TILES_Y    = 23;
  localparam int RECT_W         = 16;
  localparam int TILE_ID_W      = 10;
  localparam int GID_W          = 16;
  localparam int DEPTH_W        = 16;

  typedef struct packed {
    logic [RECT_W-1:0] xmin;
    logic [RECT_W-1:0] xmax;
    logic [RECT_W-1:0] ymin;
    logic [RECT_W-1:0] ymax;
  } tile_rect_t;

  typedef struct packed {
    logic [TILE_ID_W-1:0] tile_id;
    logic [GID_W-1:0]     gauss_id;
    logic [DEPTH_W-1:0]   depth;
  } tile_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT
  } bin_state_t;

endpackage

// File: rtl/tile_rect_calc.sv
// Centre/extent to clamped tile rectangle, purely combinational.
// Two guard bits keep x+-rx exact for any extent.
module tile_rect_calc
  import gs_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_SHIFT = DEF_TILE_SHIFT,
  parameter int TILES_X    = DEF_TILES_X,
  parameter int TILES_Y    = DEF_TILES_Y
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] rx,
  input  logic [DATA_WIDTH-1:0] ry,
  output tile_rect_t            rect,
  output logic                  empty
);

  localparam int W = DATA_WIDTH + 2;
  localparam logic signed [W-1:0] ROUND = W'((1 << TILE_SHIFT) - 1);

  function automatic logic [RECT_W-1:0] clamp_t(
    input logic signed [W-1:0] v,
    input int                  lim
  );
    logic signed [W-1:0] s;
    s = v >>> TILE_SHIFT;
    if (s < 0) return '0;
    else if (s > lim) return RECT_W'(lim);
    else return RECT_W'(s);
  endfunction

  logic signed [W-1:0] sx, sy, erx, ery;

  assign sx  = W'($signed(x));
  assign sy  = W'($signed(y));
  assign erx = {2'b00, rx};
  assign ery = {2'b00, ry};

  always_comb begin
    rect.xmin = clamp_t(sx - erx, TILES_X);
    rect.xmax = clamp_t(sx + erx + ROUND, TILES_X);
    rect.ymin = clamp_t(sy - ery, TILES_Y);
    rect.ymax = clamp_t(sy + ery + ROUND, TILES_Y);
  end

  assign empty = (rect.xmin >= rect.xmax) ||
                 (rect.ymin >= rect.ymax);

endmodule

// File: rtl/gaussian_tile_binner.sv
// Bins one projected Gaussian into row-major tile entries.
// TILE_BINNER_STATS_EN adds saturating entry/cull counters.
module gaussian_tile_binner
  import gs_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int TILE_SHIFT    = DEF_TILE_SHIFT,
  parameter int TILES_X       = DEF_TILES_X,
  parameter int TILES_Y       = DEF_TILES_Y,
  parameter int ID_WIDTH      = 16,
  parameter int TILE_ID_WIDTH = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    p_project_i [3],
  input  logic [DATA_WIDTH-1:0]    Ttrans_i [3],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TILE_ID_WIDTH-1:0] tile_id_o,
  output logic [ID_WIDTH-1:0]      gauss_id_o,
  output logic [DATA_WIDTH-1:0]    depth_o,
  output logic                     last_o,
  output logic                     cull_o
`ifdef TILE_BINNER_STATS_EN
  ,
  output logic [31:0]              stat_entries_o,
  output logic [31:0]              stat_culled_o
`endif
);

  localparam int RW = 32;

  bin_state_t            state;
  logic [DATA_WIDTH-1:0] x_q, y_q, rx_q, ry_q;
  logic [ID_WIDTH-1:0]   gid_cnt;
  logic [RECT_W-1:0]     tx, ty;
  logic [RECT_W-1:0]     xmin_q, xmax_q, ymax_q;
  logic [RW-1:0]         row_q;
  tile_rect_t            rect_c;
  logic                  empty_c;
  logic                  accept;

  logic [RECT_W-1:0]     nx, ny, lx, ly;
  logic [RW-1:0]         nrow;
  logic                  nlast;

  logic unused_ext;
  assign unused_ext = ^Ttrans_i[2];

  tile_rect_calc #(
    .DATA_WIDTH(DATA_WIDTH),
    .TILE_SHIFT(TILE_SHIFT),
    .TILES_X   (TILES_X),
    .TILES_Y   (TILES_Y)
  ) u_rect (
    .x    (x_q),
    .y    (y_q),
    .rx   (rx_q),
    .ry   (ry_q),
    .rect (rect_c),
    .empty(empty_c)
  );

  assign accept = in_valid && in_ready;

  // Next entry: first tile when leaving CALC, else row-major step.
  always_comb begin
    nx   = xmin_q;
    ny   = ty;
    nrow = row_q;
    lx   = xmax_q;
    ly   = ymax_q;
    if (state == CALC) begin
      nx   = rect_c.xmin;
      ny   = rect_c.ymin;
      nrow = RW'(rect_c.ymin) * RW'(TILES_X);
      lx   = rect_c.xmax;
      ly   = rect_c.ymax;
    end else if (tx == xmax_q - 1'b1) begin
      ny   = ty + 1'b1;
      nrow = row_q + RW'(TILES_X);
    end else begin
      nx   = tx + 1'b1;
    end
    nlast = (nx == lx - 1'b1) && (ny == ly - 1'b1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      last_o     <= 1'b0;
      cull_o     <= 1'b0;
      tile_id_o  <= '0;
      gauss_id_o <= '0;
      depth_o    <= '0;
      gid_cnt    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      tx         <= '0;
      ty         <= '0;
      row_q      <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
    end else begin
      cull_o <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready   <= 1'b0;
            x_q        <= p_project_i[0];
            y_q        <= p_project_i[1];
            depth_o    <= p_project_i[2];
            rx_q       <= Ttrans_i[0];
            ry_q       <= Ttrans_i[1];
            gauss_id_o <= gid_cnt;
            gid_cnt    <= gid_cnt + 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          xmin_q <= rect_c.xmin;
          xmax_q <= rect_c.xmax;
          ymax_q <= rect_c.ymax;
          if (empty_c || depth_o == '0) begin
            cull_o   <= 1'b1;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            out_valid <= 1'b1;
            tx        <= nx;
            ty        <= ny;
            row_q     <= nrow;
            tile_id_o <= TILE_ID_WIDTH'(nrow + RW'(nx));
            last_o    <= nlast;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_o) begin
              out_valid <= 1'b0;
              last_o    <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              tx        <= nx;
              ty        <= ny;
              row_q     <= nrow;
              tile_id_o <= TILE_ID_WIDTH'(nrow + RW'(nx));
              last_o    <= nlast;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TILE_BINNER_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_entries_o <= '0;
      stat_culled_o  <= '0;
    end else begin
      if (out_valid && out_ready && stat_entries_o != '1)
        stat_entries_o <= stat_entries_o + 1'b1;
      if (cull_o && stat_culled_o != '1)
        stat_culled_o <= stat_culled_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gaussian_tile_binner.sv
// Table-driven bench for gaussian_tile_binner.
// Reference model fills an entry queue; DUT output pops it.
module tb_gaussian_tile_binner;

  localparam int TX = 40;
  localparam int TY = 23;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] p_project [3];
  logic [15:0] ttrans [3];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  tile_id_o;
  logic [15:0] gauss_id_o;
  logic [15:0] depth_o;
  logic        last_o;
  logic        cull_o;
`ifdef TILE_BINNER_STATS_EN
  logic [31:0] stat_entries_o;
  logic [31:0] stat_culled_o;
`endif

  gaussian_tile_binner dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .p_project_i(p_project),
    .Ttrans_i   (ttrans),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .tile_id_o  (tile_id_o),
    .gauss_id_o (gauss_id_o),
    .depth_o    (depth_o),
    .last_o     (last_o),
    .cull_o     (cull_o)
`ifdef TILE_BINNER_STATS_EN
    ,
    .stat_entries_o(stat_entries_o),
    .stat_culled_o (stat_culled_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, rx, ry, d;
    int mode;
    int cnt, first, last;
    bit rst3;
  } vec_t;

  typedef struct {
    int tile;
    int gid;
    int depth;
    bit last;
  } ent_t;

  vec_t vecs [12];
  ent_t exp_q [$];
  int   applied = 0;
  int   miscompares = 0;
  int   gid_model = 0;
  bit   exp_cull;

  task automatic chk(input string nm, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int fdiv(input int a);
    if (a >= 0) return a / 16;
    return -((-a + 15) / 16);
  endfunction

  function automatic int clampi(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  task automatic model(input int x, y, rx, ry, d);
    int x0, x1, y0, y1;
    x0 = clampi(fdiv(x - rx), TX);
    x1 = clampi(fdiv(x + rx + 15), TX);
    y0 = clampi(fdiv(y - ry), TY);
    y1 = clampi(fdiv(y + ry + 15), TY);
    exp_cull = (x0 >= x1) || (y0 >= y1) || (d == 0);
    if (!exp_cull)
      for (int ty = y0; ty < y1; ty++)
        for (int tx = x0; tx < x1; tx++)
          exp_q.push_back('{ty * TX + tx, gid_model, d,
                            (ty == y1 - 1) && (tx == x1 - 1)});
    gid_model = (gid_model + 1) % 65536;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    k, got, first_t, last_t;
    bit    done, hold;
    int    h_tile, h_gid, h_dep, h_last;
    ent_t  e;
    string tg;
    tg = $sformatf("v%0d", idx);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tg, "_in_ready"}, int'(in_ready), 1);
    p_project[0] = 16'(v.x);
    p_project[1] = 16'(v.y);
    p_project[2] = 16'(v.d);
    ttrans[0]    = 16'(v.rx);
    ttrans[1]    = 16'(v.ry);
    ttrans[2]    = 16'hdead;
    in_valid     = 1'b1;
    model(v.x, v.y, v.rx, v.ry, v.d);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tg, "_calc_quiet"}, int'({out_valid, cull_o, in_ready}), 0);
    done = 0; hold = 0; got = 0; first_t = -1; last_t = -1; k = 0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
      if (hold) begin
        chk({tg, "_stall_hold"},
            int'(out_valid && tile_id_o == 10'(h_tile) &&
                 gauss_id_o == 16'(h_gid) && depth_o == 16'(h_dep) &&
                 last_o == h_last[0]), 1);
        hold = 0;
      end
      out_ready = (v.mode == 0) ? 1'b1 : (k % 3 == 1);
      if (k == 1) chk({tg, "_latency"}, int'(out_valid | cull_o), 1);
      if (cull_o) begin
        chk({tg, "_cull_cnt"}, got, v.cnt);
        chk({tg, "_cull_ready"}, int'(in_ready), 1);
        chk({tg, "_cull_valid"}, int'(out_valid), 0);
        done = 1;
      end else if (out_valid) begin
        if (out_ready) begin
          got++;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = '{-1, -1, -1, 1'b0};
          chk({tg, "_tile"}, int'(tile_id_o), e.tile);
          chk({tg, "_gid"}, int'(gauss_id_o), e.gid);
          chk({tg, "_depth"}, int'(depth_o), e.depth);
          chk({tg, "_last"}, int'(last_o), int'(e.last));
          if (got == 1) first_t = int'(tile_id_o);
          last_t = int'(tile_id_o);
          if (last_o) begin
            done = 1;
          end else if (v.rst3 && got == 3) begin
            @(negedge clk);
            out_ready = 1'b0;
            rst_i     = 1'b1;
            @(negedge clk);
            chk({tg, "_rst_valid"}, int'(out_valid), 0);
            chk({tg, "_rst_last"}, int'(last_o), 0);
            chk({tg, "_rst_gid"}, int'(gauss_id_o), 0);
            chk({tg, "_rst_tile"}, int'(tile_id_o), 0);
            chk({tg, "_rst_ready"}, int'(in_ready), 0);
            rst_i = 1'b0;
            exp_q.delete();
            gid_model = 0;
            done = 1;
          end
        end else begin
          hold   = 1;
          h_tile = int'(tile_id_o);
          h_gid  = int'(gauss_id_o);
          h_dep  = int'(depth_o);
          h_last = int'(last_o);
        end
      end
    end
    chk({tg, "_done"}, int'(done), 1);
    if (!v.rst3) begin
      chk({tg, "_count"}, got, v.cnt);
      if (v.cnt > 0) begin
        chk({tg, "_first"}, first_t, v.first);
        chk({tg, "_lastid"}, last_t, v.last);
      end
      chk({tg, "_leftover"}, exp_q.size(), 0);
      @(negedge clk);
      chk({tg, "_ready_after"}, int'({in_ready, out_valid}), 2);
    end
    out_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    vecs[0]  = '{40, 40, 16, 16, 200, 0, 9, 41, 123, 1'b1};
    vecs[1]  = '{40, 40, 8, 8, 100, 0, 1, 82, 82, 1'b0};
    vecs[2]  = '{40, 40, 16, 16, 200, 0, 9, 41, 123, 1'b0};
    vecs[3]  = '{-100, 40, 8, 8, 50, 0, 0, 0, 0, 1'b0};
    vecs[4]  = '{635, 360, 16, 16, 77, 0, 4, 878, 919, 1'b0};
    vecs[5]  = '{635, 360, 16, 16, 77, 1, 4, 878, 919, 1'b0};
    vecs[6]  = '{40, 40, 8, 8, 0, 0, 0, 0, 0, 1'b0};
    vecs[7]  = '{16, 16, 0, 0, 9, 0, 0, 0, 0, 1'b0};
    vecs[8]  = '{17, 17, 0, 0, 9, 0, 1, 41, 41, 1'b0};
    vecs[9]  = '{-32768, 32767, 65535, 65535, 5, 0, 920, 0, 919, 1'b0};
    vecs[10] = '{640, 100, 0, 0, 3, 0, 0, 0, 0, 1'b0};
    vecs[11] = '{40, 40, 16, 16, 300, 1, 9, 41, 123, 1'b0};
    for (int i = 0; i < 3; i++) begin
      p_project[i] = '0;
      ttrans[i]    = '0;
    end
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        int'({in_ready, out_valid, last_o, cull_o}), 0);
    chk("reset_data", int'(tile_id_o) + int'(gauss_id_o) + int'(depth_o), 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", int'(in_ready), 1);
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
